// File: rtl/spi_slave.sv
// spi_slave: SPI slave turning MOSI frames into 10-bit command words and shifting read data out on MISO.
// Optional macro SPI_SLAVE_TX_TIMEOUT_EN bounds the READ_DATA wait for tx_valid to 15 cycles.
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [3:0] out_cnt;
  logic [8:0] rx_sh;
  logic [7:0] tx_sh;
  logic done;
  logic loaded;
  logic rd_addr_seen;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic timed_out;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      MISO <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rd_addr_seen <= 1'b0;
      cnt <= '0;
      out_cnt <= '0;
      rx_sh <= '0;
      tx_sh <= '0;
      done <= 1'b0;
      loaded <= 1'b0;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
      wait_cnt <= '0;
      timed_out <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      MISO <= 1'b0;
      if (state != IDLE && SS_n) begin
        state <= IDLE;
        cnt <= '0;
        out_cnt <= '0;
        rx_sh <= '0;
        tx_sh <= '0;
        done <= 1'b0;
        loaded <= 1'b0;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
        wait_cnt <= '0;
        timed_out <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (!SS_n) state <= CHK_CMD;
          CHK_CMD: state <= MOSI ? (rd_addr_seen ? READ_DATA : READ_ADD) : WRITE;
          default: begin
            if (!done) begin
              rx_sh <= {rx_sh[7:0], MOSI};
              cnt <= cnt + 4'd1;
              if (cnt == 4'd9) begin
                cnt <= '0;
                done <= 1'b1;
                rx_data <= {rx_sh, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD) rd_addr_seen <= 1'b1;
                if (state == READ_DATA) rd_addr_seen <= 1'b0;
              end
            end else if (state == READ_DATA) begin
              // rx_valid still high marks the strobe cycle, where tx_valid is not yet accepted
              if (loaded) begin
                if (out_cnt != 4'd0) begin
                  MISO <= tx_sh[7];
                  tx_sh <= {tx_sh[6:0], 1'b0};
                  out_cnt <= out_cnt - 4'd1;
                end
              end
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
              else if (!timed_out) begin
                if (tx_valid && !rx_valid) begin
                  MISO <= tx_data[7];
                  tx_sh <= {tx_data[6:0], 1'b0};
                  out_cnt <= 4'd7;
                  loaded <= 1'b1;
                end else if (wait_cnt == 4'd15) begin
                  timed_out <= 1'b1;
                  rd_addr_seen <= 1'b0;
                end else begin
                  wait_cnt <= wait_cnt + 4'd1;
                end
              end
`else
              else if (tx_valid && !rx_valid) begin
                MISO <= tx_data[7];
                tx_sh <= {tx_data[6:0], 1'b0};
                out_cnt <= 4'd7;
                loaded <= 1'b1;
              end
`endif
            end
          end
        endcase
      end
    end
  end
endmodule
